// File: rtl/pa_fpu_pipe_ctrl_pkg.sv
// rtl/pa_fpu_pipe_ctrl_pkg.sv - configuration defaults and helpers for the FPU pipe controller
package pa_fpu_pipe_ctrl_pkg;

    localparam int CFG_STAGES     = 3;
    localparam int CFG_SHORT_LAST = 1;
    localparam int CFG_ID_W       = 2;
    localparam int CFG_DENORM_CYC = 1;
    localparam int CNT_W          = 3;

    // Stages before the short-result stage forward every op; from there on
    // only extended ops keep travelling down the pipe.
    function automatic logic fwd_all(input int idx, input int short_last);
        return idx < short_last;
    endfunction

endpackage

// File: rtl/gated_clk_cell.sv
// rtl/gated_clk_cell.sv - glitch-free clock gate with global, module, local and scan enables
module gated_clk_cell (
    input  logic i_clk,
    input  logic i_global_en,
    input  logic i_module_en,
    input  logic i_local_en,
    input  logic i_scan_en,
    output logic o_clk
);

    logic w_en;
    logic r_en;

    assign w_en = (i_global_en && (i_module_en || i_local_en)) || i_scan_en;

    // Enable captured in the low phase so a gated pulse is never truncated.
    always_ff @(negedge i_clk) begin
        r_en <= w_en;
    end

    assign o_clk = i_clk & r_en;

endmodule

// File: rtl/pa_fpu_pipe_ctrl_stage.sv
// rtl/pa_fpu_pipe_ctrl_stage.sv - one execute-stage slice: valid, extended flag and its clock gate
module pa_fpu_pipe_stage (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_global_en,
    input  logic i_module_en,
    input  logic i_scan_en,
    input  logic i_prev_gate,
    input  logic i_offer,
    input  logic i_ext,
    input  logic i_stall,
    input  logic i_cancel,
    output logic o_vld,
    output logic o_ext
);

    logic w_gclk;
    logic r_vld;
    logic r_ext;

    gated_clk_cell u_icg (
        .i_clk       (i_clk),
        .i_global_en (i_global_en),
        .i_module_en (i_module_en),
        .i_local_en  (i_prev_gate || r_vld),
        .i_scan_en   (i_scan_en),
        .o_clk       (w_gclk)
    );

    // Cancel beats stall; a stalled stage keeps both valid and ext flag.
    always_ff @(posedge w_gclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= 1'b0;
            r_ext <= 1'b0;
        end else if (i_cancel) begin
            r_vld <= 1'b0;
        end else if (!i_stall) begin
            r_vld <= i_offer;
            r_ext <= i_ext;
        end
    end

    assign o_vld = r_vld;
    assign o_ext = r_ext;

endmodule

// File: rtl/pa_fpu_pipe_ctrl.sv
// rtl/pa_fpu_pipe_ctrl.sv - FPU execute pipe control: EX1 denormal sequencer and EX2+ valid chain
module pa_fpu_pipe_ctrl
    import pa_fpu_pipe_ctrl_pkg::*;
#(
    parameter int STAGES     = CFG_STAGES,
    parameter int SHORT_LAST = CFG_SHORT_LAST,
    parameter int ID_W       = CFG_ID_W,
    parameter int DENORM_CYC = CFG_DENORM_CYC
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst_b,
    input  logic              cp0_yy_clk_en,
    input  logic              cp0_fpu_icg_en,
    input  logic              pad_yy_icg_scan_en,
    input  logic              ex1_sel,
    input  logic              ex1_sel_gate,
    input  logic [ID_W-1:0]   ex1_denorm_id,
    input  logic              ex1_ext,
    input  logic              ex1_cancel,
    input  logic              ex1_stall,
    input  logic [STAGES-1:0] stage_stall,
    input  logic [STAGES-1:0] stage_cancel,
    input  logic [STAGES-1:0] stage_early,
    output logic              ex1_cmplt,
    output logic              denorm_stall,
    output logic              id_reg_set,
    output logic [STAGES-1:0] stage_vld,
    output logic [STAGES-1:0] pipe_down,
    output logic              result_vld,
    output logic              long_result_vld
);

    localparam logic [CNT_W-1:0] DENORM_CNT_INIT = CNT_W'(DENORM_CYC - 1);

    logic [ID_W-1:0]   r_id;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_busy;
    logic              w_id_nz;
    logic              w_cnt_z;
    logic              w_den_gclk;
    logic [STAGES-1:0] w_vld;
    logic [STAGES-1:0] w_ext;
    logic [STAGES-1:0] w_offer;
    logic [STAGES-1:0] w_in_ext;
    logic [STAGES-1:0] w_prev_gate;
    logic [STAGES-2:0] w_fwd;
    logic              w_unused;

    assign w_busy  = |r_id;
    assign w_id_nz = |ex1_denorm_id;
    assign w_cnt_z = (r_cnt == '0);

    assign denorm_stall = ex1_sel && (w_busy ? !w_cnt_z : w_id_nz);
    assign ex1_cmplt    = ex1_sel && (w_busy ? w_cnt_z : !w_id_nz);
    assign id_reg_set   = w_busy;

    gated_clk_cell u_den_icg (
        .i_clk       (forever_cpuclk),
        .i_global_en (cp0_yy_clk_en),
        .i_module_en (cp0_fpu_icg_en),
        .i_local_en  ((ex1_sel_gate && w_id_nz) || w_busy),
        .i_scan_en   (pad_yy_icg_scan_en),
        .o_clk       (w_den_gclk)
    );

    // The first stall cycle is the idle cycle that loads the counter, so it
    // starts at DENORM_CYC-1 and completion lands on the cycle it reads zero.
    always_ff @(posedge w_den_gclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_id  <= '0;
            r_cnt <= '0;
        end else if (ex1_cancel || (w_busy && (!ex1_sel || w_cnt_z))) begin
            r_id  <= '0;
            r_cnt <= '0;
        end else if (w_busy) begin
            r_cnt <= r_cnt - 1'b1;
        end else if (ex1_sel && w_id_nz) begin
            r_id  <= ex1_denorm_id;
            r_cnt <= DENORM_CNT_INIT;
        end
    end

    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            assign w_offer[gi]     = ex1_cmplt && !ex1_cancel && !ex1_stall;
            assign w_in_ext[gi]    = ex1_ext;
            assign w_prev_gate[gi] = ex1_sel_gate;
            assign pipe_down[gi]   = ex1_sel && !stage_stall[gi];
        end else begin : g_rest
            assign w_offer[gi]     = w_vld[gi-1] && !stage_cancel[gi-1] && !stage_early[gi-1]
                                     && !stage_stall[gi-1] && w_fwd[gi-1];
            assign w_in_ext[gi]    = w_ext[gi-1];
            assign w_prev_gate[gi] = w_vld[gi-1];
            assign pipe_down[gi]   = w_vld[gi-1] && !stage_stall[gi] && !stage_early[gi-1]
                                     && w_fwd[gi-1];
        end

        if (gi < STAGES - 1) begin : g_fwd
            assign w_fwd[gi] = fwd_all(gi, SHORT_LAST) || w_ext[gi];
        end

        pa_fpu_pipe_stage u_stage (
            .i_clk       (forever_cpuclk),
            .i_rst_n     (cpurst_b),
            .i_global_en (cp0_yy_clk_en),
            .i_module_en (cp0_fpu_icg_en),
            .i_scan_en   (pad_yy_icg_scan_en),
            .i_prev_gate (w_prev_gate[gi]),
            .i_offer     (w_offer[gi]),
            .i_ext       (w_in_ext[gi]),
            .i_stall     (stage_stall[gi]),
            .i_cancel    (stage_cancel[gi]),
            .o_vld       (w_vld[gi]),
            .o_ext       (w_ext[gi])
        );
    end

    // The last stage has no downstream, so its early-completion bit is moot.
    assign w_unused = stage_early[STAGES-1];

    assign stage_vld       = w_vld;
    assign result_vld      = w_vld[SHORT_LAST] && !w_ext[SHORT_LAST];
    assign long_result_vld = w_vld[STAGES-1] && w_ext[STAGES-1];

endmodule

// File: tb/tb_pa_fpu_pipe_ctrl.sv
// tb/tb_pa_fpu_pipe_ctrl.sv - directed and randomized checks of pa_fpu_pipe_ctrl against a behavioural model
module tb_pa_fpu_pipe_ctrl;

    localparam int S  = 3;
    localparam int SL = 1;
    localparam int IW = 2;
    localparam int DC = 3;

    logic          clk;
    logic          rst_n;
    logic          clk_en;
    logic          icg_en;
    logic          scan_en;
    logic          sel;
    logic          sel_gate;
    logic [IW-1:0] id;
    logic          ext;
    logic          e1_cancel;
    logic          e1_stall;
    logic [S-1:0]  ss;
    logic [S-1:0]  sc;
    logic [S-1:0]  se;
    logic          cmplt;
    logic          dstall;
    logic          idset;
    logic [S-1:0]  vld;
    logic [S-1:0]  pd;
    logic          res;
    logic          lres;

    int checks = 0;
    int fails  = 0;

    int           m_age;
    logic         m_v [S];
    logic         m_e [S];
    logic         x_stall;
    logic         x_cmplt;
    logic         x_set;
    logic [S-1:0] x_vld;
    logic [S-1:0] x_pd;
    logic         x_res;
    logic         x_long;

    pa_fpu_pipe_ctrl #(
        .STAGES     (S),
        .SHORT_LAST (SL),
        .ID_W       (IW),
        .DENORM_CYC (DC)
    ) dut (
        .forever_cpuclk     (clk),
        .cpurst_b           (rst_n),
        .cp0_yy_clk_en      (clk_en),
        .cp0_fpu_icg_en     (icg_en),
        .pad_yy_icg_scan_en (scan_en),
        .ex1_sel            (sel),
        .ex1_sel_gate       (sel_gate),
        .ex1_denorm_id      (id),
        .ex1_ext            (ext),
        .ex1_cancel         (e1_cancel),
        .ex1_stall          (e1_stall),
        .stage_stall        (ss),
        .stage_cancel       (sc),
        .stage_early        (se),
        .ex1_cmplt          (cmplt),
        .denorm_stall       (dstall),
        .id_reg_set         (idset),
        .stage_vld          (vld),
        .pipe_down          (pd),
        .result_vld         (res),
        .long_result_vld    (lres)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_ex1(input logic s, input logic [IW-1:0] d, input logic x);
        sel      = s;
        sel_gate = s;
        id       = d;
        ext      = x;
    endtask

    task automatic idle_inputs;
        set_ex1(1'b0, '0, 1'b0);
        e1_cancel = 1'b0;
        e1_stall  = 1'b0;
        ss = '0;
        sc = '0;
        se = '0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Age counts cycles since a denormal sequence started; the op stalls
    // until its age reaches DC and completes on exactly that cycle.
    task automatic model_eval;
        logic busy;
        busy    = (m_age > 0);
        x_set   = busy;
        x_stall = sel && (busy ? (m_age < DC) : (id != 0));
        x_cmplt = sel && (busy ? (m_age == DC) : (id == 0));
        for (int i = 0; i < S; i++) x_vld[i] = m_v[i];
        x_pd[0] = sel && !ss[0];
        for (int i = 1; i < S; i++)
            x_pd[i] = m_v[i-1] && !ss[i] && !se[i-1] && ((i - 1) < SL || m_e[i-1]);
        x_res  = m_v[SL] && !m_e[SL];
        x_long = m_v[S-1] && m_e[S-1];
    endtask

    task automatic model_clock;
        logic nv [S];
        logic ne [S];
        logic off;
        for (int i = 0; i < S; i++) begin
            if (i == 0) off = x_cmplt && !e1_cancel && !e1_stall;
            else off = m_v[i-1] && !sc[i-1] && !se[i-1] && !ss[i-1] && ((i - 1) < SL || m_e[i-1]);
            nv[i] = m_v[i];
            ne[i] = m_e[i];
            if (sc[i]) begin
                nv[i] = 1'b0;
            end else if (!ss[i]) begin
                nv[i] = off;
                if (i == 0) ne[i] = ext;
                else ne[i] = m_e[i-1];
            end
        end
        for (int i = 0; i < S; i++) begin
            m_v[i] = nv[i];
            m_e[i] = ne[i];
        end
        if (e1_cancel) m_age = 0;
        else if (m_age > 0) m_age = (!sel || m_age == DC) ? 0 : m_age + 1;
        else if (sel && id != 0) m_age = 1;
    endtask

    task automatic reset_all;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        m_age = 0;
        for (int i = 0; i < S; i++) begin
            m_v[i] = 1'b0;
            m_e[i] = 1'b0;
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        clk_en  = 1'b1;
        icg_en  = 1'b0;
        scan_en = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cmplt, dstall, idset, res, lres} !== 5'b0) begin
            fails++;
            $display("FAIL reset_scalars got=%b exp=00000", {cmplt, dstall, idset, res, lres});
        end
        checks++;
        if (vld !== '0) begin fails++; $display("FAIL reset_stage_vld got=%b exp=000", vld); end
        checks++;
        if (pd !== '0) begin fails++; $display("FAIL reset_pipe_down got=%b exp=000", pd); end
        rst_n = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if ({cmplt, idset, vld} !== '0) begin
            fails++;
            $display("FAIL post_reset_idle got=%b exp=0", {cmplt, idset, vld});
        end
        step();
    endtask

    task automatic test_short_op;
        set_ex1(1'b1, '0, 1'b0);
        @(negedge clk);
        checks++;
        if ({cmplt, dstall} !== 2'b10) begin
            fails++;
            $display("FAIL short_c0_cmplt_stall got=%b exp=10", {cmplt, dstall});
        end
        step();
        set_ex1(1'b0, '0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            logic [S-1:0] ev;
            ev = (c == 1) ? 3'b001 : (c == 2) ? 3'b010 : 3'b000;
            @(negedge clk);
            checks++;
            if (vld !== ev) begin fails++; $display("FAIL short_vld_c%0d got=%b exp=%b", c, vld, ev); end
            checks++;
            if ({res, lres} !== {c == 2, 1'b0}) begin
                fails++;
                $display("FAIL short_res_c%0d got=%b exp=%b", c, {res, lres}, {c == 2, 1'b0});
            end
            step();
        end
    endtask

    task automatic test_denorm;
        set_ex1(1'b1, 2'b01, 1'b0);
        for (int c = 0; c <= 3; c++) begin
            logic [2:0] ex;
            ex = (c < 3) ? {1'b1, 1'b0, c != 0} : 3'b011;
            @(negedge clk);
            checks++;
            if ({dstall, cmplt, idset} !== ex) begin
                fails++;
                $display("FAIL denorm_c%0d stall_cmplt_set got=%b exp=%b", c, {dstall, cmplt, idset}, ex);
            end
            step();
        end
        set_ex1(1'b0, '0, 1'b0);
        @(negedge clk);
        checks++;
        if ({vld, idset} !== 4'b0010) begin
            fails++;
            $display("FAIL denorm_c4 vld_set got=%b exp=0010", {vld, idset});
        end
        repeat (3) step();
    endtask

    task automatic test_ext_stall;
        set_ex1(1'b1, '0, 1'b1);
        step();
        set_ex1(1'b0, '0, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            logic [S-1:0] ev;
            ev = (c == 1) ? 3'b001 : (c <= 4) ? 3'b010 : (c == 5) ? 3'b100 : 3'b000;
            ss = (c == 2 || c == 3) ? 3'b010 : 3'b000;
            @(negedge clk);
            checks++;
            if (vld !== ev) begin fails++; $display("FAIL ext_vld_c%0d got=%b exp=%b", c, vld, ev); end
            checks++;
            if ({res, lres} !== {1'b0, c == 5}) begin
                fails++;
                $display("FAIL ext_res_c%0d got=%b exp=%b", c, {res, lres}, {1'b0, c == 5});
            end
            step();
        end
        ss = '0;
    endtask

    task automatic test_early;
        set_ex1(1'b1, '0, 1'b0);
        step();
        set_ex1(1'b0, '0, 1'b0);
        se = 3'b001;
        @(negedge clk);
        checks++;
        if ({vld[0], pd[1]} !== 2'b10) begin
            fails++;
            $display("FAIL early_c1 vld0_pd1 got=%b exp=10", {vld[0], pd[1]});
        end
        step();
        se = '0;
        @(negedge clk);
        checks++;
        if (vld !== 3'b000) begin fails++; $display("FAIL early_c2_vld got=%b exp=000", vld); end
        repeat (2) step();
    endtask

    task automatic test_cancel_stall;
        set_ex1(1'b1, '0, 1'b0);
        step();
        set_ex1(1'b0, '0, 1'b0);
        step();
        ss = 3'b010;
        sc = 3'b010;
        @(negedge clk);
        checks++;
        if (vld !== 3'b010) begin fails++; $display("FAIL cs_c2_vld got=%b exp=010", vld); end
        step();
        ss = '0;
        sc = '0;
        @(negedge clk);
        checks++;
        if (vld[1] !== 1'b0) begin fails++; $display("FAIL cs_c3_vld1 got=%b exp=0", vld[1]); end
        repeat (2) step();
    endtask

    task automatic test_reset_mid;
        set_ex1(1'b1, '0, 1'b0);
        step();
        set_ex1(1'b1, 2'b01, 1'b0);
        step();
        @(negedge clk);
        checks++;
        if ({idset, vld} !== 4'b1010) begin
            fails++;
            $display("FAIL rmid_pre set_vld got=%b exp=1010", {idset, vld});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({idset, vld, cmplt} !== 5'b0) begin
            fails++;
            $display("FAIL rmid_async set_vld_cmplt got=%b exp=00000", {idset, vld, cmplt});
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_ex1(1'b1, '0, 1'b0);
        #1;
        checks++;
        if ({cmplt, dstall} !== 2'b10) begin
            fails++;
            $display("FAIL rmid_new_cmplt got=%b exp=10", {cmplt, dstall});
        end
        step();
        set_ex1(1'b0, '0, 1'b0);
        @(negedge clk);
        checks++;
        if (vld !== 3'b001) begin fails++; $display("FAIL rmid_new_vld got=%b exp=001", vld); end
        step();
        @(negedge clk);
        checks++;
        if (res !== 1'b1) begin fails++; $display("FAIL rmid_new_res got=%b exp=1", res); end
        repeat (2) step();
    endtask

    task automatic test_random;
        reset_all();
        for (int c = 0; c < 1500 && fails < 40; c++) begin
            set_ex1(($urandom % 10) < 7,
                    (($urandom % 4) == 0) ? IW'($urandom_range(1, 3)) : '0,
                    1'($urandom % 2));
            e1_cancel = ($urandom % 20) == 0;
            e1_stall  = ($urandom % 10) == 0;
            for (int i = 0; i < S; i++) begin
                ss[i] = ($urandom % 7) == 0;
                sc[i] = ($urandom % 20) == 0;
                se[i] = ($urandom % 10) == 0;
            end
            @(negedge clk);
            model_eval();
            checks++;
            if ({dstall, cmplt, idset} !== {x_stall, x_cmplt, x_set}) begin
                fails++;
                $display("FAIL rnd_ex1 cyc=%0d got=%b exp=%b", c, {dstall, cmplt, idset}, {x_stall, x_cmplt, x_set});
            end
            checks++;
            if (vld !== x_vld) begin fails++; $display("FAIL rnd_vld cyc=%0d got=%b exp=%b", c, vld, x_vld); end
            checks++;
            if (pd !== x_pd) begin fails++; $display("FAIL rnd_pipe_down cyc=%0d got=%b exp=%b", c, pd, x_pd); end
            checks++;
            if ({res, lres} !== {x_res, x_long}) begin
                fails++;
                $display("FAIL rnd_result cyc=%0d got=%b exp=%b", c, {res, lres}, {x_res, x_long});
            end
            @(posedge clk);
            model_clock();
            #1;
        end
        idle_inputs();
        repeat (4) step();
    endtask

    initial begin
        test_reset();
        test_short_op();
        test_denorm();
        test_ext_stall();
        test_early();
        test_cancel_stall();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/pa_fpu_pipe_ctrl.md
PA_FPU_PIPE_CTRL -- requirements
Module: pa_fpu_pipe_ctrl

Interface
REQ-001 Parameter STAGES, default 3: number of stages after EX1 (EX2..EX(STAGES+1)); legal range 2..6.
REQ-002 Parameter SHORT_LAST, default 1: stage index at which short (non-extended) ops produce their result; legal range 0..STAGES-2.
REQ-003 Parameter ID_W, default 2: width of the EX1 denormal-operand id.
REQ-004 Parameter DENORM_CYC, default 1: number of EX1 stall cycles per denormal pre-normalisation; legal range 1..7.
REQ-005 forever_cpuclk  in  1  single clock, all flops positive-edge.
REQ-006 cpurst_b  in  1  asynchronous active-low reset.
REQ-007 cp0_yy_clk_en, cp0_fpu_icg_en, pad_yy_icg_scan_en  in  1 each  global enable, module enable and scan enable for clock gating.
REQ-008 ex1_sel / ex1_sel_gate  in  1 / 1  EX1 instruction valid / its gating-timing copy.
REQ-009 ex1_denorm_id  in  ID_W  non-zero means an EX1 operand needs pre-normalisation.
REQ-010 ex1_ext  in  1  EX1 op is extended (runs to the last stage, e.g. MAC).
REQ-011 ex1_cancel, ex1_stall  in  1 each  EX1 flush and external EX1 stall.
REQ-012 stage_stall, stage_cancel, stage_early  in  STAGES each  per-stage stall, flush and early completion; bit i is stage EX(i+2).
REQ-013 ex1_cmplt, denorm_stall, id_reg_set  out  1 each  EX1 complete, EX1 held for denormal, denormal sequence in progress.
REQ-014 stage_vld, pipe_down  out  STAGES each  stage valid; bit 0 = EX1->EX2 advance, bit i = stage i-1 -> stage i.
REQ-015 result_vld, long_result_vld  out  1 each  short result in stage SHORT_LAST; extended result in stage STAGES-1.

Function
REQ-016 Denormal sequencer: id_reg (ID_W) plus down-counter cnt (3 bits); busy means id_reg != 0.
REQ-017 denorm_stall = ex1_sel && (busy ? cnt != 0 : ex1_denorm_id != 0).
REQ-018 Idle, ex1_sel, id != 0, no ex1_cancel: load id_reg <= id and cnt <= DENORM_CYC-1; denorm_stall is therefore high for exactly DENORM_CYC consecutive cycles.
REQ-019 Busy with cnt != 0: cnt decrements by one per cycle.
REQ-020 Busy with cnt == 0: ex1_cmplt = 1 in that cycle; id_reg and cnt clear at the next edge.
REQ-021 ex1_cmplt = ex1_sel && (busy ? cnt == 0 : id == 0).
REQ-022 ex1_cancel, or ex1_sel low while busy, clears id_reg and cnt at the next edge; ex1_cancel has priority over a new load.
REQ-023 id_reg_set = busy.
REQ-024 Stage 0 capture, priority order:
  - stage_cancel[0]: vld cleared
  - else !stage_stall[0]: vld <= ex1_cmplt && !ex1_cancel && !ex1_stall, ext_q[0] <= ex1_ext
  - else hold
REQ-025 Stage i>0 capture, priority order:
  - stage_cancel[i]: vld cleared
  - else !stage_stall[i]: vld <= v[i-1] && !stage_cancel[i-1] && !stage_early[i-1] && !stage_stall[i-1] && (i-1 < SHORT_LAST || ext_q[i-1]); ext_q[i] <= ext_q[i-1]
  - else hold
REQ-026 pipe_down[0] = ex1_sel && !stage_stall[0].
REQ-027 pipe_down[i] = v[i-1] && !stage_stall[i] && !stage_early[i-1] && (i-1 < SHORT_LAST || ext_q[i-1]).
REQ-028 result_vld = v[SHORT_LAST] && !ext_q[SHORT_LAST]; long_result_vld = v[STAGES-1] && ext_q[STAGES-1].
REQ-029 Latency with no stalls and DENORM_CYC=1: short op result at cycle SHORT_LAST+1 after EX1; extended op at cycle STAGES; each denormal adds DENORM_CYC cycles.
REQ-030 A stage cancel and a stall on the same stage in one cycle: cancel wins.
REQ-031 An early-completed instruction does not advance; the downstream stage fills with a bubble.

Reset
REQ-032 Reset asserted:
  - id_reg, cnt, all vld and all ext_q clear to 0
  - every output is 0 while ex1_sel is 0
REQ-033 Reset mid-sequence aborts it; no ex1_cmplt or stage valid survives reset.

Structure
REQ-034 Clock gating: one gated_clk_cell per stage, enable = previous valid (ex1_sel_gate for stage 0) || own vld.
REQ-035 Denormal gated_clk_cell enable = (ex1_sel_gate && id != 0) || busy.
REQ-036 Sub-module pa_fpu_pipe_stage: one stage slice (vld, ext_q, gating cell), generated STAGES times.
REQ-037 STAGES, SHORT_LAST and DENORM_CYC defaults live in cpu_cfig.h.

Verification
REQ-038 Defaults, short op, id=0, no stalls: ex1_cmplt=1 at cycle 0; result_vld=1 at cycle 2; long_result_vld never asserts.
REQ-039 DENORM_CYC=3, id=2'b01: denorm_stall high for cycles 0-2; ex1_cmplt at cycle 3; stage_vld[0] at cycle 4.
REQ-040 Extended op, stage_stall[1]=1 for 2 cycles: stage_vld[1] holds 2 cycles; long_result_vld at cycle 5.
REQ-041 stage_early[0]=1 with a short op in stage 0: stage_vld[1]=0 next cycle; pipe_down[1]=0.
REQ-042 stage_cancel[1] and stage_stall[1] together with stage_vld[1]=1: stage_vld[1]=0 next cycle.
REQ-043 Reset asserted during denormal cycle 1 of 3: id_reg_set=0 and all stage_vld=0 immediately; a new op after release completes normally.
